// File: rtl/ldpc_cn_unit.sv
// LDPC check-node functional unit.
// Accumulates a check node's incoming 8-bit LLRs across instructions (min1,
// min2, argmin, sign parity, per-edge signs) and returns extrinsic min-sum
// messages. Fixed one-cycle latency with no writeback backpressure.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   flush_i        kills the request this cycle and the pending result
//   fu_data_i      operation, operand_a (LLR in [7:0]), operand_b (edge), trans_id
//   cn_valid_i     request valid
//   cn_ready_o     unit can accept (low only in the drain cycle after CLR)
//   result_o       registered result
//   cn_valid_o     result valid
//   cn_trans_id_o  trans_id of result
//   cn_err_o       sticky error: degree overflow or edge index out of range

package ldpc_cn_pkg;
   localparam int XLEN          = 32;
   localparam int TRANS_ID_BITS = 3;

   typedef logic [3:0] fu_op_t;

   localparam fu_op_t LDPC_CN_CLR  = 4'd0;
   localparam fu_op_t LDPC_CN_ACC  = 4'd1;
   localparam fu_op_t LDPC_CN_MIN1 = 4'd2;
   localparam fu_op_t LDPC_CN_MIN2 = 4'd3;
   localparam fu_op_t LDPC_CN_IDX  = 4'd4;
   localparam fu_op_t LDPC_CN_OUT  = 4'd5;
   localparam fu_op_t LDPC_CN_STAT = 4'd6;

   typedef struct packed {
      fu_op_t                   op;
      logic [XLEN-1:0]          operand_a;
      logic [XLEN-1:0]          operand_b;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } fu_data_t;
endpackage

// state    | meaning
// ---------+-----------------------------------------------
// ST_RUN   | accepting requests
// ST_DRAIN | one cycle after an accepted CLR, not ready
module ldpc_cn_unit
   import ldpc_cn_pkg::*;
#(
   parameter int DEG_MAX = 32,
   parameter int MAG_MAX = 127
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  fu_data_t                 fu_data_i,
   input  logic                     cn_valid_i,
   output logic                     cn_ready_o,
   output logic [XLEN-1:0]          result_o,
   output logic                     cn_valid_o,
   output logic [TRANS_ID_BITS-1:0] cn_trans_id_o,
   output logic                     cn_err_o
);

   localparam int IW = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;

   localparam logic [0:0]      ST_RUN   = 1'b0;
   localparam logic [0:0]      ST_DRAIN = 1'b1;
   localparam logic [7:0]      MAG_SAT  = MAG_MAX[7:0];
   localparam logic [IW:0]     CNT_FULL = DEG_MAX[IW:0];
   localparam logic [XLEN-1:0] DEG_LIM  = XLEN'(DEG_MAX);

   logic [0:0]               st_q, st_d;
   logic [7:0]               min1_q, min1_d, min2_q, min2_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic                     parity_q, parity_d;
   logic [DEG_MAX-1:0]       sign_q, sign_d;
   logic [IW:0]              count_q, count_d;
   logic                     err_q, err_d;
   logic [XLEN-1:0]          result_q, res_d;
   logic                     valid_q;
   logic [TRANS_ID_BITS-1:0] tid_q;

   logic                     accept;
   logic [7:0]               a8, abs_raw, mag, m, msg;
   logic                     s, sg, b_oob;
   logic [IW-1:0]            i;
   logic                     unused_bits;

   assign unused_bits = ^fu_data_i.operand_a[XLEN-1:8];

   assign cn_ready_o = (st_q == ST_RUN);
   assign accept     = cn_valid_i & cn_ready_o & ~flush_i;

   // -128 negates to 0x80 (128 unsigned), which the clamp brings back to MAG_MAX.
   assign a8      = fu_data_i.operand_a[7:0];
   assign s       = a8[7];
   assign abs_raw = s ? (~a8 + 8'd1) : a8;
   assign mag     = (abs_raw > MAG_SAT) ? MAG_SAT : abs_raw;

   assign b_oob = (fu_data_i.operand_b >= DEG_LIM);
   assign i     = fu_data_i.operand_b[IW-1:0];

   // Extrinsic message: exclude the edge's own contribution from both min and sign.
   assign m   = (i == idx_q) ? min2_q : min1_q;
   assign sg  = parity_q ^ sign_q[i];
   assign msg = sg ? (8'd0 - m) : m;

   always_comb begin
      st_d     = ST_RUN;
      min1_d   = min1_q;
      min2_d   = min2_q;
      idx_d    = idx_q;
      parity_d = parity_q;
      sign_d   = sign_q;
      count_d  = count_q;
      err_d    = err_q;
      res_d    = '0;
      if (accept) begin
         case (fu_data_i.op)
            LDPC_CN_CLR: begin
               st_d     = ST_DRAIN;
               min1_d   = MAG_SAT;
               min2_d   = MAG_SAT;
               idx_d    = '0;
               parity_d = 1'b0;
               sign_d   = '0;
               count_d  = '0;
               err_d    = 1'b0;
            end
            LDPC_CN_ACC: begin
               if ((count_q == CNT_FULL) || b_oob) begin
                  err_d = 1'b1;
                  res_d = XLEN'(count_q);
               end else begin
                  sign_d[i] = s;
                  parity_d  = parity_q ^ s;
                  count_d   = count_q + 1'b1;
                  // Strict compares: on ties the earlier edge keeps argmin.
                  if (mag < min1_q) begin
                     min2_d = min1_q;
                     min1_d = mag;
                     idx_d  = i;
                  end else if (mag < min2_q) begin
                     min2_d = mag;
                  end
                  res_d = XLEN'(count_d);
               end
            end
            LDPC_CN_MIN1: res_d = XLEN'(min1_q);
            LDPC_CN_MIN2: res_d = XLEN'(min2_q);
            LDPC_CN_IDX:  res_d = XLEN'(idx_q);
            LDPC_CN_OUT: begin
               if (b_oob) begin
                  err_d = 1'b1;
               end else if (count_q != '0) begin
                  res_d = {{(XLEN-8){msg[7]}}, msg};
               end
            end
            LDPC_CN_STAT: res_d = XLEN'({err_q, parity_q, count_q});
            default:      res_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q     <= ST_RUN;
         min1_q   <= MAG_SAT;
         min2_q   <= MAG_SAT;
         idx_q    <= '0;
         parity_q <= 1'b0;
         sign_q   <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         tid_q    <= '0;
      end else begin
         st_q     <= st_d;
         min1_q   <= min1_d;
         min2_q   <= min2_d;
         idx_q    <= idx_d;
         parity_q <= parity_d;
         sign_q   <= sign_d;
         count_q  <= count_d;
         err_q    <= err_d;
         valid_q  <= accept;
         if (accept) begin
            result_q <= res_d;
            tid_q    <= fu_data_i.trans_id;
         end
      end
   end

   // A flush arriving while a result is presented kills that result too.
   assign cn_valid_o    = valid_q & ~flush_i;
   assign result_o      = result_q;
   assign cn_trans_id_o = tid_q;
   assign cn_err_o      = err_q;

endmodule

// File: tb/tb_ldpc_cn_unit.sv
module tb_ldpc_cn_unit;
   import ldpc_cn_pkg::*;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   logic flush   = 1'b0;
   logic cn_valid_i = 1'b0;
   fu_data_t fu_data;

   logic                     ready32, valid32, err32;
   logic [XLEN-1:0]          result32;
   logic [TRANS_ID_BITS-1:0] tid32;
   logic                     ready4, valid4, err4;
   logic [XLEN-1:0]          result4;
   logic [TRANS_ID_BITS-1:0] tid4;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   ldpc_cn_unit #(.DEG_MAX(32), .MAG_MAX(127)) dut32 (
      .clk_i(clk_sys), .rst_ni(rst_n), .flush_i(flush), .fu_data_i(fu_data),
      .cn_valid_i(cn_valid_i), .cn_ready_o(ready32), .result_o(result32),
      .cn_valid_o(valid32), .cn_trans_id_o(tid32), .cn_err_o(err32)
   );

   ldpc_cn_unit #(.DEG_MAX(4), .MAG_MAX(127)) dut4 (
      .clk_i(clk_sys), .rst_ni(rst_n), .flush_i(flush), .fu_data_i(fu_data),
      .cn_valid_i(cn_valid_i), .cn_ready_o(ready4), .result_o(result4),
      .cn_valid_o(valid4), .cn_trans_id_o(tid4), .cn_err_o(err4)
   );

   typedef struct {
      fu_op_t      op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input fu_op_t op, input logic [7:0] a, input logic [7:0] b,
                      input logic [31:0] exp, input string name);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = name;
      tbl.push_back(v);
   endtask

   // Upper operand_a bits carry junk: only [7:0] is the LLR.
   task automatic drive(input fu_op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] tid, input logic fl);
      @(negedge clk_sys);
      fu_data.op        = op;
      fu_data.operand_a = {24'hA5A5A5, a};
      fu_data.operand_b = {24'h0, b};
      fu_data.trans_id  = tid;
      cn_valid_i        = 1'b1;
      flush             = fl;
   endtask

   task automatic do_op(input fu_op_t op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] tid, input logic fl);
      drive(op, a, b, tid, fl);
      @(posedge clk_sys);
      #1;
      cn_valid_i = 1'b0;
      flush      = 1'b0;
   endtask

   task automatic clr(input string name);
      do_op(LDPC_CN_CLR, 8'h00, 8'h00, 3'd0, 1'b0);
      chk({name, "_ready_drain"}, {31'b0, ready32}, 32'd0);
      @(posedge clk_sys);
      #1;
      chk({name, "_ready_back"}, {31'b0, ready32}, 32'd1);
   endtask

   initial begin
      fu_data = '0;

      #2;
      chk("rst_valid",  {31'b0, valid32}, 32'd0);
      chk("rst_result", result32, 32'd0);
      chk("rst_err",    {31'b0, err32}, 32'd0);
      chk("rst_tid",    {29'b0, tid32}, 32'd0);
      @(negedge clk_sys);
      rst_n = 1'b1;
      @(posedge clk_sys);
      #1;
      chk("rst_ready", {31'b0, ready32}, 32'd1);

      add(LDPC_CN_CLR,  8'h00, 8'd0,  32'd0,          "clr0");
      add(LDPC_CN_ACC,  8'h05, 8'd0,  32'd1,          "acc_p5_i0");
      add(LDPC_CN_ACC,  8'hFD, 8'd1,  32'd2,          "acc_m3_i1");
      add(LDPC_CN_ACC,  8'h09, 8'd2,  32'd3,          "acc_p9_i2");
      add(LDPC_CN_ACC,  8'hFD, 8'd3,  32'd4,          "acc_m3_i3");
      add(LDPC_CN_MIN1, 8'h00, 8'd0,  32'd3,          "min1");
      add(LDPC_CN_MIN2, 8'h00, 8'd0,  32'd3,          "min2_tie");
      add(LDPC_CN_IDX,  8'h00, 8'd0,  32'd1,          "idx_tie");
      add(LDPC_CN_STAT, 8'h00, 8'd0,  32'd4,          "stat_basic");
      add(LDPC_CN_OUT,  8'h00, 8'd1,  32'hFFFF_FFFD,  "out_i1");
      add(LDPC_CN_OUT,  8'h00, 8'd2,  32'd3,          "out_i2");
      add(LDPC_CN_OUT,  8'h00, 8'd0,  32'd3,          "out_i0");
      add(LDPC_CN_OUT,  8'h00, 8'd3,  32'hFFFF_FFFD,  "out_i3");
      add(LDPC_CN_CLR,  8'h00, 8'd0,  32'd0,          "clr1");
      add(LDPC_CN_ACC,  8'h80, 8'd0,  32'd1,          "acc_m128");
      add(LDPC_CN_MIN1, 8'h00, 8'd0,  32'd127,        "min1_sat");
      add(LDPC_CN_STAT, 8'h00, 8'd0,  32'd65,         "stat_parity");
      add(LDPC_CN_CLR,  8'h00, 8'd0,  32'd0,          "clr2");
      add(LDPC_CN_OUT,  8'h00, 8'd1,  32'd0,          "out_empty");
      add(LDPC_CN_ACC,  8'h0A, 8'd5,  32'd1,          "acc_p10_i5");
      add(LDPC_CN_OUT,  8'h00, 8'd5,  32'd127,        "out_single");
      add(LDPC_CN_MIN2, 8'h00, 8'd0,  32'd127,        "min2_single");
      add(LDPC_CN_IDX,  8'h00, 8'd0,  32'd5,          "idx_single");
      add(4'hF,         8'h33, 8'd1,  32'd0,          "unknown_op");
      add(LDPC_CN_OUT,  8'h00, 8'd40, 32'd0,          "out_oob");
      add(LDPC_CN_STAT, 8'h00, 8'd0,  32'd129,        "stat_err");
      add(LDPC_CN_CLR,  8'h00, 8'd0,  32'd0,          "clr3");
      add(LDPC_CN_STAT, 8'h00, 8'd0,  32'd0,          "stat_cleared");

      foreach (tbl[k]) begin
         do_op(tbl[k].op, tbl[k].a, tbl[k].b, 3'(k), 1'b0);
         chk(tbl[k].name, result32, tbl[k].exp);
         chk({tbl[k].name, "_valid"}, {31'b0, valid32}, 32'd1);
         chk({tbl[k].name, "_tid"}, {29'b0, tid32}, {29'b0, 3'(k)});
         if (tbl[k].op == LDPC_CN_CLR) begin
            chk({tbl[k].name, "_ready_drain"}, {31'b0, ready32}, 32'd0);
            @(posedge clk_sys);
            #1;
            chk({tbl[k].name, "_ready_back"}, {31'b0, ready32}, 32'd1);
         end
      end

      // Degree overflow on the 4-edge instance.
      clr("ovf_clr");
      for (int k = 0; k < 4; k++) begin
         do_op(LDPC_CN_ACC, 8'h01, 8'(k), 3'd1, 1'b0);
         chk("ovf_acc", result4, 32'(k + 1));
      end
      chk("ovf_err_before", {31'b0, err4}, 32'd0);
      do_op(LDPC_CN_ACC, 8'h01, 8'd0, 3'd2, 1'b0);
      chk("ovf_acc5_count", result4, 32'd4);
      chk("ovf_acc5_err", {31'b0, err4}, 32'd1);
      do_op(LDPC_CN_ACC, 8'h00, 8'd1, 3'd3, 1'b0);
      chk("ovf_acc6_count", result4, 32'd4);
      do_op(LDPC_CN_MIN1, 8'h00, 8'd0, 3'd4, 1'b0);
      chk("ovf_min1_kept", result4, 32'd1);
      do_op(LDPC_CN_IDX, 8'h00, 8'd0, 3'd5, 1'b0);
      chk("ovf_idx_kept", result4, 32'd0);
      clr("ovf_clr2");
      chk("ovf_err_cleared", {31'b0, err4}, 32'd0);
      do_op(LDPC_CN_ACC, 8'h01, 8'd7, 3'd6, 1'b0);
      chk("oob_err4", {31'b0, err4}, 32'd1);
      chk("oob_result4", result4, 32'd0);
      chk("inrange_err32", {31'b0, err32}, 32'd0);
      chk("inrange_result32", result32, 32'd1);
      clr("oob_clr");
      chk("oob_err_cleared", {31'b0, err4}, 32'd0);

      // Back-to-back ACC then OUT.
      do_op(LDPC_CN_ACC, 8'h02, 8'd0, 3'd1, 1'b0);
      chk("b2b_acc", result32, 32'd1);
      do_op(LDPC_CN_OUT, 8'h00, 8'd1, 3'd2, 1'b0);
      chk("b2b_out", result32, 32'd2);
      chk("b2b_tid", {29'b0, tid32}, 32'd2);

      // Flush in the request cycle.
      do_op(LDPC_CN_ACC, 8'hF9, 8'd2, 3'd3, 1'b1);
      chk("flush_req_valid", {31'b0, valid32}, 32'd0);
      do_op(LDPC_CN_STAT, 8'h00, 8'd0, 3'd4, 1'b0);
      chk("flush_req_state", result32, 32'd1);

      // Flush while the result is presented: result killed, state kept.
      drive(LDPC_CN_ACC, 8'h05, 8'd3, 3'd5, 1'b0);
      @(posedge clk_sys);
      #1;
      cn_valid_i = 1'b0;
      flush      = 1'b1;
      #1;
      chk("flush_pend_valid", {31'b0, valid32}, 32'd0);
      flush = 1'b0;
      do_op(LDPC_CN_STAT, 8'h00, 8'd0, 3'd6, 1'b0);
      chk("flush_pend_state", result32, 32'd2);

      // Asynchronous reset mid-accumulation.
      do_op(LDPC_CN_ACC, 8'h01, 8'd7, 3'd7, 1'b0);
      chk("arst_pre_err4", {31'b0, err4}, 32'd1);
      drive(LDPC_CN_ACC, 8'h03, 8'd4, 3'd1, 1'b0);
      @(posedge clk_sys);
      #2;
      cn_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_valid",  {31'b0, valid32}, 32'd0);
      chk("arst_result", result32, 32'd0);
      chk("arst_tid",    {29'b0, tid32}, 32'd0);
      chk("arst_err4",   {31'b0, err4}, 32'd0);
      chk("arst_ready",  {31'b0, ready32}, 32'd1);
      @(negedge clk_sys);
      rst_n = 1'b1;
      do_op(LDPC_CN_STAT, 8'h00, 8'd0, 3'd2, 1'b0);
      chk("arst_stat", result32, 32'd0);
      do_op(LDPC_CN_MIN1, 8'h00, 8'd0, 3'd3, 1'b0);
      chk("arst_min1", result32, 32'd127);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ldpc_cn_unit.md
Name: ldpc_cn_unit

Overview:
- Stateful LDPC check-node functional unit. Sits in ex_stage beside the ALU and consumes the same 8-bit LLR operands that the ALU's LDPC_MIN/ABS/ADD_SAT/SUB_SAT ops produce.
- Accumulates a check node's incoming LLRs over successive instructions: min1, min2, argmin, sign parity and per-edge signs.
- Returns extrinsic min-sum messages on request.
- Adds fu_op entries LDPC_CN_CLR, LDPC_CN_ACC, LDPC_CN_MIN1, LDPC_CN_MIN2, LDPC_CN_IDX, LDPC_CN_OUT and LDPC_CN_STAT.

Parameters:
- DEG_MAX, 32, maximum check-node degree (edges per node). Index width IW = $clog2(DEG_MAX).
- MAG_MAX, 127, saturation magnitude of stored and returned values.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill request presented this cycle and any pending result
- fu_data_i  in  fu_data_t  operator, operand_a (LLR in [7:0]), operand_b (edge index), trans_id
- cn_valid_i  in  1  request valid (fu == LDPC_CN issued)
- cn_ready_o  out  1  unit can accept request
- result_o  out  riscv::XLEN  result, registered
- cn_valid_o  out  1  result valid
- cn_trans_id_o  out  TRANS_ID_BITS  trans_id of result
- cn_err_o  out  1  sticky error: degree overflow or index out of range

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_ni. Clock and reset ports are clk_i/rst_ni.
- Reset values:
  - Outputs: result_o=0, cn_valid_o=0, cn_trans_id_o=0, cn_err_o=0, cn_ready_o=1 one cycle after reset release.
  - State: min1=min2=MAG_MAX, idx=0, parity=0, sign_vec=0, count=0.
- Handshake:
  - Accept when cn_valid_i & cn_ready_o & ~flush_i.
  - cn_ready_o=0 only in the cycle immediately after an accepted CLR. This is the clear-drain cycle.
- Latency is fixed at 1 cycle: an op accepted in cycle T gives cn_valid_o=1 in T+1 with its trans_id. No writeback backpressure.
- State updates at the end of the accept cycle. Back-to-back ACC then OUT sees the updated state, so there is no bubble.
- Magnitude: mag = |signed(operand_a[7:0])|, clamped to MAG_MAX, so -128 gives 127. Sign s = operand_a[7].
- CLR: all state returns to reset values, cn_err_o=0. Result is 0.
- ACC (i = operand_b[IW-1:0]):
  - If count==DEG_MAX or operand_b >= DEG_MAX: no state change, cn_err_o<=1.
  - Else:
    - sign_vec[i]<=s; parity<=parity^s; count<=count+1.
    - If mag<min1: min2<=min1, min1<=mag, idx<=i.
    - Else if mag<min2: min2<=mag.
  - Comparisons are strict, so on ties the first edge keeps argmin.
  - Result: zero-extended post-op count.
- MIN1, MIN2, IDX: result is the zero-extended field.
- OUT (i = operand_b):
  - m = (i==idx) ? min2 : min1.
  - sg = parity ^ sign_vec[i].
  - Result is the 8-bit value (sg ? -m : m), sign-extended to XLEN.
  - count==0: result 0. Out-of-range i: result 0 and cn_err_o<=1.
- STAT: result = {cn_err_o, parity, count}, zero-extended (count in low IW+1 bits).
- Unknown operator with cn_valid_i: accepted, result 0, no state change.
- flush_i:
  - Request in the same cycle is not accepted and has no state effect.
  - A pending result is suppressed: cn_valid_o=0 next cycle.
  - Committed state is not rolled back.
- cn_err_o is cleared only by CLR or reset. An overflow ACC never corrupts min1, min2 or idx.
- Reset mid-stream: all state and outputs return to reset values asynchronously. The in-flight result is lost.

Test Plan:
- Basic accumulate and read-back:
  - Stimulus: CLR, then ACC of (+5,i0), (-3,i1), (+9,i2), (-3,i3).
  - Required: ACC results 1,2,3,4; then MIN1=3, MIN2=3, IDX=1, STAT parity=0, count=4.
- Extrinsic message: after the previous scenario, OUT i1 -> 0x...FD (-3).
  - Derivation: m=min2=3, sg=0^1=1.
  - Also OUT i2 -> 3.
  - Also OUT i0 -> +3 (sg=0^0=0).
- Saturation:
  - CLR, ACC (-128,i0) -> MIN1=127.
  - OUT i5 after a single ACC (+10,i5) -> m=min2=127, result +127.
- Degree overflow:
  - With DEG_MAX=4: CLR, then 5 ACCs of +1.
  - Required: 5th result count=4, cn_err_o=1, min1 unchanged.
  - ACC with operand_b=7 also sets cn_err_o.
  - CLR clears cn_err_o; cn_ready_o=0 exactly one cycle after the CLR.
- Back-to-back and flush:
  - ACC (+2,i0) in cycle T and OUT i1 in T+1: OUT returns +2.
  - ACC with flush_i=1 in the same cycle: no state change, no cn_valid_o.
  - Flush in T+1 after an accept in T: cn_valid_o stays low in T+1.
- Async reset: assert rst_ni low mid-accumulation between clock edges.
  - Required: outputs and state are zero/MAG_MAX immediately; the first post-reset STAT returns 0.
